// File: rtl/reg_access_arbiter.sv
// rtl/reg_access_arbiter.sv - round-robin two-port arbiter sequencing register file accesses
module reg_access_arbiter #(
    parameter int ADDR_W      = 3,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              decEn,
    output logic [ADDR_W-1:0] decAddr,
    output logic              regWe,
    output logic [DATA_W-1:0] regWdata,
    input  logic [DATA_W-1:0] regRdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ACK} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t     state, next_state;
    logic [3:0] cnt;
    logic       last_grant;
    logic       owner;
    logic       we_l;
    logic       grant_valid;
    logic       winner;
    logic       last_access;
    logic       enter_last_access;

    always_comb begin
        grant_valid       = req0 | req1;
        winner            = (req0 & req1) ? ~last_grant : req1;
        last_access       = (state == ACCESS) && (cnt == 4'd0);
        // Strobe is registered, so it is armed one cycle before the final ACCESS cycle.
        enter_last_access = ((state == SETUP) && (CNT_INIT == 4'd0)) ||
                            ((state == ACCESS) && (cnt == 4'd1));
        next_state        = state;
        case (state)
            IDLE:    if (grant_valid) next_state = SETUP;
            SETUP:   next_state = ACCESS;
            ACCESS:  if (cnt == 4'd0) next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            decEn      <= 1'b0;
            regWe      <= 1'b0;
            busy       <= 1'b0;
            decAddr    <= '0;
            regWdata   <= '0;
            rdata      <= '0;
            cnt        <= 4'd0;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            we_l       <= 1'b0;
        end else begin
            decEn <= (next_state == SETUP) || (next_state == ACCESS);
            busy  <= (next_state != IDLE);
            regWe <= we_l && enter_last_access;
            ack0  <= last_access && !owner;
            ack1  <= last_access && owner;

            // Requester inputs are captured once here and never re-sampled.
            if (state == IDLE && grant_valid) begin
                owner      <= winner;
                last_grant <= winner;
                we_l       <= winner ? we1 : we0;
                decAddr    <= winner ? addr1 : addr0;
                regWdata   <= winner ? wdata1 : wdata0;
            end

            if (state == SETUP) begin
                cnt <= CNT_INIT;
            end else if (state == ACCESS && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (last_access && !we_l) begin
                rdata <= regRdata;
            end
        end
    end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// tb/tb_reg_access_arbiter.sv - random and directed checks of reg_access_arbiter against a timeline model
module tb_reg_access_arbiter;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [2:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0, regRdata = '0;

    logic       ack0_o [2];
    logic       ack1_o [2];
    logic       decEn_o [2];
    logic       regWe_o [2];
    logic       busy_o [2];
    logic [7:0] rdata_o [2];
    logic [7:0] regWdata_o [2];
    logic [2:0] decAddr_o [2];

    int nvec = 0;
    int nerr = 0;
    int n = 0;

    int         wv [2] = '{1, 4};
    bit         m_act [2];
    int         m_t0 [2];
    bit         m_owner [2];
    bit         m_we [2];
    bit         m_last [2];
    logic [7:0] m_rdata [2];
    logic [7:0] m_wdata [2];
    logic [2:0] m_addr [2];

    always #5 clk = ~clk;

    reg_access_arbiter #(.ADDR_W(3), .DATA_W(8), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rstN(rstN),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0_o[0]),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1_o[0]),
        .rdata(rdata_o[0]), .decEn(decEn_o[0]), .decAddr(decAddr_o[0]),
        .regWe(regWe_o[0]), .regWdata(regWdata_o[0]), .regRdata(regRdata),
        .busy(busy_o[0])
    );

    reg_access_arbiter #(.ADDR_W(3), .DATA_W(8), .WAIT_CYCLES(4)) u_w4 (
        .clk(clk), .rstN(rstN),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0_o[1]),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1_o[1]),
        .rdata(rdata_o[1]), .decEn(decEn_o[1]), .decAddr(decAddr_o[1]),
        .regWe(regWe_o[1]), .regWdata(regWdata_o[1]), .regRdata(regRdata),
        .busy(busy_o[1])
    );

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s w%0d cycle %0d observed=%0h expected=%0h", tag, wv[i], n, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i]   = 1'b0;
            m_last[i]  = 1'b1;
            m_rdata[i] = '0;
            m_wdata[i] = '0;
            m_addr[i]  = '0;
        end
    endtask

    // A transaction granted in cycle t0 occupies t0..t0+2+W; its outputs follow from k = n - t0.
    task automatic check_cycle();
        for (int i = 0; i < 2; i++) begin
            int k;
            int w;
            bit act;
            k   = n - m_t0[i];
            w   = wv[i];
            act = m_act[i] && (k <= 2 + w);
            chk("decEn", i, decEn_o[i], act && k >= 1 && k <= 1 + w);
            chk("regWe", i, regWe_o[i], act && m_we[i] && k == 1 + w);
            chk("ack0", i, ack0_o[i], act && k == 2 + w && !m_owner[i]);
            chk("ack1", i, ack1_o[i], act && k == 2 + w && m_owner[i]);
            chk("busy", i, busy_o[i], act && k >= 1);
            chk("decAddr", i, decAddr_o[i], m_addr[i]);
            chk("regWdata", i, regWdata_o[i], m_wdata[i]);
            chk("rdata", i, rdata_o[i], m_rdata[i]);
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            int k;
            bit act;
            bit win;
            k   = n - m_t0[i];
            act = m_act[i] && (k <= 2 + wv[i]);
            if (act && k == 1 + wv[i] && !m_we[i]) m_rdata[i] = regRdata;
            if (!act && (req0 || req1)) begin
                win        = (req0 && req1) ? !m_last[i] : req1;
                m_last[i]  = win;
                m_owner[i] = win;
                m_we[i]    = win ? we1 : we0;
                m_addr[i]  = win ? addr1 : addr0;
                m_wdata[i] = win ? wdata1 : wdata0;
                m_t0[i]    = n;
                m_act[i]   = 1'b1;
            end
        end
    endtask

    task automatic cycle(input logic rn,
                         input logic r0, input logic w0, input logic [2:0] a0, input logic [7:0] d0,
                         input logic r1, input logic w1, input logic [2:0] a1, input logic [7:0] d1,
                         input logic [7:0] rd);
        @(negedge clk);
        check_cycle();
        rstN = rn;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        regRdata = rd;
        if (rstN) model_update();
        else model_reset();
        n++;
    endtask

    task automatic idle(input int c);
        for (int j = 0; j < c; j++)
            cycle(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'($urandom));
    endtask

    initial begin
        model_reset();
        cycle(1'b0, 0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00, 8'h00);
        cycle(1'b0, 0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00, 8'h00);
        idle(2);

        // write to addr 5 interrupted by reset during ACCESS
        for (int j = 0; j < 3; j++)
            cycle(1'b1, 1, 1, 3'd5, 8'hA5, 0, 0, 3'd0, 8'h00, 8'h00);
        for (int j = 0; j < 3; j++)
            cycle(1'b0, 0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00, 8'h00);

        // both requesting right after release, then sustained contention
        for (int j = 0; j < 24; j++)
            cycle(1'b1, 1, 1, 3'd1, 8'h5A, 1, 0, 3'd6, 8'hC3, 8'(8'h40 + j));
        idle(8);

        for (int j = 0; j < 3; j++)
            cycle(1'b1, 1, 1, 3'd5, 8'hA5, 0, 0, 3'd0, 8'h00, 8'h3C);
        idle(8);

        for (int j = 0; j < 3; j++)
            cycle(1'b1, 0, 0, 3'd0, 8'h00, 1, 0, 3'd2, 8'h00, 8'h3C);
        idle(8);

        for (int j = 0; j < 6; j++)
            cycle(1'b1, 0, 0, 3'd0, 8'h00, 1, 0, 3'd7, 8'h00, 8'(8'h70 + j));
        idle(8);

        // early drop: req0 present only in the grant cycle
        cycle(1'b1, 1, 1, 3'd0, 8'h11, 0, 0, 3'd0, 8'h00, 8'h00);
        idle(8);

        for (int j = 0; j < 400; j++) begin
            logic r0, r1;
            r0 = ($urandom_range(0, 9) < 6);
            r1 = ($urandom_range(0, 9) < 6);
            cycle(($urandom_range(0, 99) != 0), r0, 1'($urandom), 3'($urandom), 8'($urandom),
                  r1, 1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom));
        end
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
